// File: rtl/snn_pkg.sv
// Shared constants and types for the SNN core and its readout stage.
package snn_pkg;

    localparam int SNN_N_CH   = 3;
    localparam int SNN_DATA_W = 8;
    localparam int SNN_WINDOW = 16;

    typedef logic [1:0] snn_class_t;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } snn_buf_state_e;

endpackage

// File: rtl/snn_spike_counter.sv
// Per-channel spike counter. The count output already includes the spike
// being sampled this cycle, so the readout sees final counts on the window-end edge.
module snn_spike_counter #(
    parameter int CNT_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_spike,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] count_q, count_d;

    assign o_count = count_q + CNT_W'(i_en && i_spike);

    always_comb begin
        count_d = count_q;
        if (i_en) count_d = i_clr ? '0 : o_count;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) count_q <= '0;
        else       count_q <= count_d;
    end

endmodule

// File: rtl/snn_readout.sv
// Windowed spike-count readout: per-channel counts, argmax class, and a
// one-entry result buffer with valid/ready output and sticky overrun flag.
module snn_readout
    import snn_pkg::*;
#(
    parameter int   DATA_W = SNN_DATA_W,
    parameter int   WINDOW = SNN_WINDOW,
    localparam int  CNT_W  = $clog2(WINDOW + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data0,
    input  logic [DATA_W-1:0] i_data1,
    input  logic [DATA_W-1:0] i_data2,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [1:0]        o_class,
    output logic [CNT_W-1:0]  o_count0,
    output logic [CNT_W-1:0]  o_count1,
    output logic [CNT_W-1:0]  o_count2,
    output logic              o_overrun
);

    logic [DATA_W-1:0] data     [SNN_N_CH];
    logic [CNT_W-1:0]  cnt_fin  [SNN_N_CH];
    logic [CNT_W-1:0]  cnt_q    [SNN_N_CH];
    logic [CNT_W-1:0]  step_q;
    logic              win_end;
    snn_class_t        class_d, class_q;
    snn_buf_state_e    state_q;
    logic              valid_q, overrun_q;

    assign data[0] = i_data0;
    assign data[1] = i_data1;
    assign data[2] = i_data2;

    assign win_end = i_valid && (step_q == CNT_W'(WINDOW - 1));

    for (genvar ch = 0; ch < SNN_N_CH; ch++) begin : g_cnt
        snn_spike_counter #(.CNT_W(CNT_W)) u_cnt (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_clr   (win_end),
            .i_en    (i_valid),
            .i_spike (|data[ch]),
            .o_count (cnt_fin[ch])
        );
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)        step_q <= '0;
        else if (i_valid) step_q <= win_end ? '0 : step_q + 1'b1;
    end

    // >= comparisons make ties resolve toward the lower channel index.
    always_comb begin
        class_d = snn_class_t'(2);
        if (cnt_fin[0] >= cnt_fin[1] && cnt_fin[0] >= cnt_fin[2]) class_d = snn_class_t'(0);
        else if (cnt_fin[1] >= cnt_fin[2])                        class_d = snn_class_t'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= BUF_EMPTY;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            class_q   <= '0;
            for (int ch = 0; ch < SNN_N_CH; ch++) cnt_q[ch] <= '0;
        end else begin
            case (state_q)
                BUF_EMPTY: begin
                    if (win_end) begin
                        state_q <= BUF_FULL;
                        valid_q <= 1'b1;
                        class_q <= class_d;
                        for (int ch = 0; ch < SNN_N_CH; ch++) cnt_q[ch] <= cnt_fin[ch];
                    end
                end
                BUF_FULL: begin
                    if (i_ready) begin
                        if (win_end) begin
                            class_q <= class_d;
                            for (int ch = 0; ch < SNN_N_CH; ch++) cnt_q[ch] <= cnt_fin[ch];
                        end else begin
                            state_q <= BUF_EMPTY;
                            valid_q <= 1'b0;
                        end
                    end else if (win_end) begin
                        overrun_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= BUF_EMPTY;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_valid   = valid_q;
    assign o_class   = class_q;
    assign o_count0  = cnt_q[0];
    assign o_count1  = cnt_q[1];
    assign o_count2  = cnt_q[2];
    assign o_overrun = overrun_q;

endmodule

// File: tb/tb_snn_readout.sv
// Directed plus randomized bench for snn_readout (WINDOW=4) against a
// behavioural window/argmax/buffer model.
module tb_snn_readout;

    localparam int DW = 8;
    localparam int WIN = 4;
    localparam int CW = $clog2(WIN + 1);

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_valid = 1'b0;
    logic [DW-1:0] i_data0 = '0, i_data1 = '0, i_data2 = '0;
    logic          i_ready = 1'b0;
    logic          o_valid, o_overrun;
    logic [1:0]    o_class;
    logic [CW-1:0] o_count0, o_count1, o_count2;

    snn_readout #(.DATA_W(DW), .WINDOW(WIN)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid),
        .i_data0(i_data0), .i_data1(i_data1), .i_data2(i_data2),
        .o_valid(o_valid), .i_ready(i_ready), .o_class(o_class),
        .o_count0(o_count0), .o_count1(o_count1), .o_count2(o_count2),
        .o_overrun(o_overrun)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad = 0;

    // reference model state
    int acc [3];
    int nsamp;
    int mcnt [3];
    int mcls;
    bit mval, movr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin acc[c] = 0; mcnt[c] = 0; end
        nsamp = 0; mcls = 0; mval = 0; movr = 0;
    endtask

    // Apply one cycle of inputs, advance the model by the rules, compare all outputs.
    task automatic step(input bit v, input bit rdy, input bit rst, input int d0, input int d1, input int d2);
        int  fin [3];
        int  best;
        bit  wend;
        i_valid = v; i_ready = rdy; i_rst = rst;
        i_data0 = d0[DW-1:0]; i_data1 = d1[DW-1:0]; i_data2 = d2[DW-1:0];
        @(posedge i_clk);
        if (rst) begin
            model_reset();
        end else begin
            wend = 0;
            if (v) begin
                if (d0[DW-1:0] != 0) acc[0]++;
                if (d1[DW-1:0] != 0) acc[1]++;
                if (d2[DW-1:0] != 0) acc[2]++;
                nsamp++;
                if (nsamp == WIN) begin
                    wend = 1;
                    for (int c = 0; c < 3; c++) begin fin[c] = acc[c]; acc[c] = 0; end
                    nsamp = 0;
                end
            end
            if (wend) begin
                if (!mval || rdy) begin
                    best = 0;
                    for (int c = 1; c < 3; c++) if (fin[c] > fin[best]) best = c;
                    mcls = best;
                    for (int c = 0; c < 3; c++) mcnt[c] = fin[c];
                    mval = 1;
                end else begin
                    movr = 1;
                end
            end else if (mval && rdy) begin
                mval = 0;
            end
        end
        #1;
        check("valid", o_valid, mval);
        check("overrun", o_overrun, movr);
        if (mval) begin
            check("class", o_class, mcls);
            check("count0", o_count0, mcnt[0]);
            check("count1", o_count1, mcnt[1]);
            check("count2", o_count2, mcnt[2]);
        end
    endtask

    function automatic int rnd_data();
        return ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 255)) : 0;
    endfunction

    initial begin
        model_reset();

        // reset held 3 cycles with arbitrary inputs
        for (int i = 0; i < 3; i++)
            step($urandom_range(0, 1), $urandom_range(0, 1), 1, rnd_data(), rnd_data(), rnd_data());
        check("rst_valid", o_valid, 0);
        check("rst_class", o_class, 0);
        check("rst_count0", o_count0, 0);
        check("rst_overrun", o_overrun, 0);

        // basic window
        step(1, 1, 0, 10, 20, 30);
        step(1, 1, 0, 0, 0, 30);
        step(1, 1, 0, 0, 20, 30);
        check("basic_pre_valid", o_valid, 0);
        step(1, 1, 0, 1, 0, 0);
        check("basic_valid", o_valid, 1);
        check("basic_c0", o_count0, 2);
        check("basic_c1", o_count1, 2);
        check("basic_c2", o_count2, 3);
        check("basic_class", o_class, 2);
        step(0, 1, 0, 0, 0, 0);
        check("basic_one_cycle", o_valid, 0);

        // all-equal tie
        for (int i = 0; i < 4; i++) step(1, 1, 0, 40, 40, 40);
        check("tie_class", o_class, 0);
        check("tie_c1", o_count1, 4);
        check("tie_c2", o_count2, 4);
        // all zero
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 0);
        check("zero_valid", o_valid, 1);
        check("zero_class", o_class, 0);
        check("zero_c0", o_count0, 0);
        step(0, 1, 0, 0, 0, 0);

        // backpressure: 9 valid steps with ready low
        for (int i = 0; i < 9; i++) begin
            step(1, 0, 0, rnd_data(), rnd_data(), rnd_data());
            if (i == 6) check("bp_no_overrun_yet", o_overrun, 0);
            if (i == 7) check("bp_overrun", o_overrun, 1);
        end
        step(0, 1, 0, 0, 0, 0);
        check("bp_drained", o_valid, 0);
        check("bp_overrun_sticky", o_overrun, 1);

        // simultaneous transfer and window end (fresh reset clears overrun)
        step(0, 0, 1, 0, 0, 0);
        check("rst_clears_overrun", o_overrun, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 5, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 7, 0);
        step(1, 1, 0, 0, 7, 0);
        check("simul_valid", o_valid, 1);
        check("simul_class", o_class, 1);
        check("simul_c1", o_count1, 4);
        check("simul_no_overrun", o_overrun, 0);
        step(0, 1, 0, 0, 0, 0);

        // gapped input: invalid cycles carry data that must be ignored
        for (int i = 0; i < 8; i++)
            if (i % 2 == 0) step(1, 1, 0, 0, 0, 9);
            else            step(0, 1, 0, 9, 9, 0);
        check("gap_class", o_class, 2);
        check("gap_c0", o_count0, 0);
        check("gap_c2", o_count2, 4);
        step(0, 1, 0, 0, 0, 0);

        // mid-window reset discards the partial window
        step(1, 1, 0, 3, 3, 3);
        step(1, 1, 0, 3, 3, 3);
        step(0, 1, 1, 3, 3, 3);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, i % 2, 1);
        check("mrst_c0", o_count0, 0);
        check("mrst_c1", o_count1, 2);
        check("mrst_c2", o_count2, 4);
        check("mrst_class", o_class, 2);

        // randomized traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 99) == 0, rnd_data(), rnd_data(), rnd_data());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/snn_readout.md
# snn_readout

Downstream readout stage for `snn_top`. Consumes the three 8-bit output-neuron channels once per timestep and counts spikes per channel over a fixed window of timesteps. At window end it selects the winning channel by argmax and presents counts plus class on a valid/ready interface. A one-entry result buffer lets counting of the next window continue while the result waits to be accepted.

## Interface
- `DATA_W`, 8: width of each input channel; must equal the `snn_top` output width.
- `WINDOW`, 16: timesteps per classification window; legal range 2..255.
- `CNT_W`, `$clog2(WINDOW+1)`: count width; derived, not overridden.

Ports:
- `i_clk`  in  1  single clock; all logic on the rising edge.
- `i_rst`  in  1  reset; synchronous, active-high.
- `i_valid`  in  1  timestep strobe; `i_data0..2` are sampled only when it is high.
- `i_data0`, `i_data1`, `i_data2`  in  `DATA_W`  neuron outputs from `snn_top`; a non-zero value is one spike.
- `o_valid`  out  1  result buffer holds an unaccepted result.
- `i_ready`  in  1  downstream accepts the result.
- `o_class`  out  2  winning channel, 0..2.
- `o_count0`, `o_count1`, `o_count2`  out  `CNT_W`  per-channel spike counts for the window.
- `o_overrun`  out  1  sticky flag: a completed window was dropped.

## Operation
- Accumulator: three spike counters plus a step counter `step` (0..WINDOW-1).
  - On `i_valid`, each counter increments when its input is non-zero.
  - `step` increments on every `i_valid` and wraps to 0.
  - No saturation logic; count ≤ WINDOW fits in `CNT_W`.
- Window end: `i_valid && step == WINDOW-1`.
  - Final counts include the current sample.
  - Counters and `step` clear to 0 on the same edge, so the next window starts on the next `i_valid` with no lost timesteps.
- Argmax: largest final count wins. Ties go to the lowest index (0 beats 1 beats 2). All-zero counts give `o_class` = 0.
- Result buffer FSM, two states:
  - EMPTY → FULL on window end: load class and counts, set `o_valid`.
  - FULL → EMPTY on `o_valid && i_ready` with no window end that cycle.
  - FULL stays FULL on transfer with a simultaneous window end; the new result loads and `o_valid` stays high.
  - FULL with window end and `!i_ready`: new result dropped, old result held, `o_overrun` ← 1.
- `o_overrun` clears only on `i_rst`.
- While `o_valid && !i_ready`, `o_class` and `o_count*` must not change.

## Timing
- Reset values: `o_valid`=0, `o_class`=0, `o_count0..2`=0, `o_overrun`=0; internal counters, `step` and FSM (EMPTY) also cleared.
- Latency: result visible with `o_valid`=1 on the cycle after the edge that samples the last window timestep (1 cycle).
- Throughput: one result per WINDOW valid timesteps. Back-to-back `i_valid` is supported.
- Handshake: a transfer occurs on a cycle where `o_valid && i_ready`. `o_valid` does not depend combinationally on `i_ready`.
- `i_valid` low: no counter or step change, no effect on the buffer.
- Reset mid-window: partial counts are discarded and any pending result is lost. The first window after reset starts on the first `i_valid` following `i_rst` low.
- `i_rst` has priority over all other events in the same cycle.

## Structure
- Package `snn_pkg`:
  - `SNN_N_CH` = 3
  - class-index typedef `snn_class_t` (2 bits)
  - default `DATA_W` / `WINDOW` constants shared with `snn_top`
- Sub-module `snn_spike_counter`: clear input, enable input, spike input, `CNT_W` count output; instantiated three times.
- Argmax and buffer FSM stay inline in `snn_readout`.

## Test plan
Run with WINDOW=4, DATA_W=8.
- Reset: hold `i_rst`=1 for 3 cycles with arbitrary inputs → all outputs 0; `o_valid` stays 0 until 4 valid timesteps have passed.
- Basic window: 4 valid steps of (10,20,30), (0,0,30), (0,20,30), (1,0,0), `i_ready`=1 → counts (2,2,3), `o_class`=2, `o_valid` high for exactly 1 cycle, one cycle after the 4th sample.
- Tie and zero cases:
  - 4 steps of (40,40,40) → counts (4,4,4), class 0.
  - 4 steps of (0,0,0) → counts (0,0,0), class 0.
- Backpressure and overrun:
  - `i_ready`=0 for 9 valid steps → first result held stable throughout; `o_overrun`=1 after the 8th step.
  - Then `i_ready`=1 → first result transferred; `o_overrun` remains 1.
- Simultaneous transfer and window end: `i_ready` rises on the exact cycle the next window completes → old result transferred, new result loaded, `o_valid` stays high, no overrun.
- Gapped input and mid-window reset:
  - `i_valid` toggling every other cycle → result after 4 strobed samples; counts ignore data on invalid cycles.
  - `i_rst` pulsed after 2 samples → the next result reflects only the 4 samples after reset.
